// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings, register IDs, status codes and E-bundle widths
package y86_pkg;
    localparam int STAT_W  = 3;
    localparam int ICODE_W = 4;
    localparam int REG_W   = 4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hf;
    localparam logic [REG_W-1:0] RSP   = 4'h4;

    localparam logic [STAT_W-1:0] S_AOK = 3'd1;
    localparam logic [STAT_W-1:0] S_HLT = 3'd2;
    localparam logic [STAT_W-1:0] S_ADR = 3'd3;
    localparam logic [STAT_W-1:0] S_INS = 3'd4;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: priority operand mux choosing valP, the youngest forwarded result, or register-file data
module fwd_sel #(
    parameter int         XLEN  = 64,
    parameter logic [3:0] RNONE = 4'hf
) (
    input  logic            use_valp,
    input  logic [XLEN-1:0] valp,
    input  logic [3:0]      src,
    input  logic [XLEN-1:0] rf_val,
    input  logic [3:0]      e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [3:0]      M_dstM,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      M_dstE,
    input  logic [XLEN-1:0] M_valE,
    input  logic [3:0]      W_dstM,
    input  logic [XLEN-1:0] W_valM,
    input  logic [3:0]      W_dstE,
    input  logic [XLEN-1:0] W_valE,
    output logic [XLEN-1:0] val
);
    logic hit;
    assign hit = src != RNONE;
    assign val = use_valp                 ? valp   :
                 !hit                     ? rf_val :
                 src == e_dstE            ? e_valE :
                 src == M_dstM            ? m_valM :
                 src == M_dstE            ? M_valE :
                 src == W_dstM            ? W_valM :
                 src == W_dstE            ? W_valE : rf_val;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode with operand forwarding and the decode/execute pipeline register
module decode_stage
    import y86_pkg::*;
#(
    parameter int         XLEN  = 64,
    parameter logic [3:0] RNONE = 4'hf,
    parameter logic [3:0] RSP   = 4'h4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [STAT_W-1:0]  D_stat,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [3:0]         D_ifun,
    input  logic [REG_W-1:0]   D_rA,
    input  logic [REG_W-1:0]   D_rB,
    input  logic [XLEN-1:0]    D_valC,
    input  logic [XLEN-1:0]    D_valP,
    output logic [REG_W-1:0]   srcA,
    output logic [REG_W-1:0]   srcB,
    input  logic [XLEN-1:0]    valA,
    input  logic [XLEN-1:0]    valB,
    input  logic [REG_W-1:0]   e_dstE,
    input  logic [XLEN-1:0]    e_valE,
    input  logic [REG_W-1:0]   M_dstE,
    input  logic [XLEN-1:0]    M_valE,
    input  logic [REG_W-1:0]   M_dstM,
    input  logic [XLEN-1:0]    m_valM,
    input  logic [REG_W-1:0]   W_dstE,
    input  logic [XLEN-1:0]    W_valE,
    input  logic [REG_W-1:0]   W_dstM,
    input  logic [XLEN-1:0]    W_valM,
    input  logic               stall_i,
    input  logic               bubble_i,
    output logic [STAT_W-1:0]  E_stat,
    output logic [ICODE_W-1:0] E_icode,
    output logic [3:0]         E_ifun,
    output logic [XLEN-1:0]    E_valC,
    output logic [XLEN-1:0]    E_valA,
    output logic [XLEN-1:0]    E_valB,
    output logic [REG_W-1:0]   E_dstE,
    output logic [REG_W-1:0]   E_dstM,
    output logic [REG_W-1:0]   E_srcA,
    output logic [REG_W-1:0]   E_srcB,
    output logic               load_use_o
);
    logic [REG_W-1:0] d_dstE, d_dstM;
    logic [XLEN-1:0]  d_valA, d_valB;

    always_comb begin
        srcA   = (D_icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? D_rA :
                 (D_icode inside {I_POPQ, I_RET}) ? RSP : RNONE;
        srcB   = (D_icode inside {I_OPQ, I_RMMOVQ, I_MRMOVQ}) ? D_rB :
                 (D_icode inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) ? RSP : RNONE;
        d_dstE = (D_icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? D_rB :
                 (D_icode inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) ? RSP : RNONE;
        d_dstM = (D_icode inside {I_MRMOVQ, I_POPQ}) ? D_rA : RNONE;
    end

    fwd_sel #(.XLEN(XLEN), .RNONE(RNONE)) u_fwd_a (
        .use_valp(D_icode == I_CALL || D_icode == I_JXX), .valp(D_valP),
        .src(srcA), .rf_val(valA),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .val(d_valA)
    );

    fwd_sel #(.XLEN(XLEN), .RNONE(RNONE)) u_fwd_b (
        .use_valp(1'b0), .valp('0),
        .src(srcB), .rf_val(valB),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .val(d_valB)
    );

    assign load_use_o = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != RNONE &&
                        (E_dstM == srcA || E_dstM == srcB);

    // stall outranks a requested bubble; reset outranks both
    always_ff @(posedge clk_i) begin
        if (rst_i || (bubble_i && !stall_i)) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= '0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (!stall_i) begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= srcA;
            E_srcB  <= srcB;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with a queued scoreboard checking the E register one cycle after issue
module tb_decode_stage;
    logic        clk_i = 0, rst_i = 0, stall_i = 0, bubble_i = 0;
    logic [2:0]  D_stat = 3'd1;
    logic [3:0]  D_icode = 4'h1, D_ifun = 0, D_rA = 4'hf, D_rB = 4'hf;
    logic [63:0] D_valC = 0, D_valP = 0;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;
    logic [3:0]  e_dstE = 4'hf, M_dstE = 4'hf, M_dstM = 4'hf, W_dstE = 4'hf, W_dstM = 4'hf;
    logic [63:0] e_valE = 0, M_valE = 0, m_valM = 0, W_valE = 0, W_valM = 0;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        load_use_o;
    logic [63:0] rf [16];

    int passed = 0, total = 0, cycle = 0;

    typedef struct {
        string       name;
        int          due;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
        logic [63:0] valC, valA, valB;
    } exp_t;
    exp_t q[$];

    assign valA = (srcA == 4'hf) ? 64'd0 : rf[srcA];
    assign valB = (srcB == 4'hf) ? 64'd0 : rf[srcB];

    decode_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .srcA(srcA), .srcB(srcB),
        .valA(valA), .valB(valB), .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE),
        .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .stall_i(stall_i), .bubble_i(bubble_i),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .load_use_o(load_use_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t mk(string n, logic [3:0] ic, logic [63:0] vc, logic [63:0] va,
                                logic [63:0] vb, logic [3:0] de, logic [3:0] dm,
                                logic [3:0] sa, logic [3:0] sb);
        exp_t e;
        e.name = n; e.due = cycle + 1; e.stat = 3'd1; e.icode = ic; e.ifun = 0;
        e.valC = vc; e.valA = va; e.valB = vb; e.dstE = de; e.dstM = dm; e.srcA = sa; e.srcB = sb;
        return e;
    endfunction

    function automatic exp_t bub(string n);
        return mk(n, 4'h1, 0, 0, 0, 4'hf, 4'hf, 4'hf, 4'hf);
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, req);
    endtask

    task automatic set_d(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb, logic [63:0] vc, logic [63:0] vp);
        D_icode = ic; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    endtask

    task automatic clr_fwd();
        e_dstE = 4'hf; M_dstE = 4'hf; M_dstM = 4'hf; W_dstE = 4'hf; W_dstM = 4'hf;
    endtask

    // monitor: the E register is sampled just after every rising edge
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cycle++;
            while (q.size() > 0 && q[0].due == cycle) begin
                exp_t e;
                logic ok;
                e = q.pop_front();
                ok = E_stat === e.stat && E_icode === e.icode && E_ifun === e.ifun &&
                     E_valC === e.valC && E_valA === e.valA && E_valB === e.valB &&
                     E_dstE === e.dstE && E_dstM === e.dstM && E_srcA === e.srcA && E_srcB === e.srcB;
                total++;
                if (ok) passed++;
                else $display("FAIL %s: got stat=%0h ic=%0h fn=%0h C=%0h A=%0h B=%0h dE=%0h dM=%0h sA=%0h sB=%0h expected stat=%0h ic=%0h fn=%0h C=%0h A=%0h B=%0h dE=%0h dM=%0h sA=%0h sB=%0h",
                              e.name, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
                              e.stat, e.icode, e.ifun, e.valC, e.valA, e.valB, e.dstE, e.dstM, e.srcA, e.srcB);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 64'h1000 + i;
        rf[1] = 64'h10; rf[2] = 5; rf[3] = 7; rf[4] = 64'h100; rf[6] = 64'h200;

        @(negedge clk_i);
        rst_i = 1; stall_i = 1; set_d(4'h6, 2, 3, 0, 0);
        q.push_back(bub("reset_init"));

        @(negedge clk_i);
        rst_i = 0; stall_i = 0; set_d(4'h6, 2, 3, 64'h11, 64'h22);
        #1; chk("opq_srcA", srcA, 2); chk("opq_srcB", srcB, 3);
        q.push_back(mk("opq_plain", 4'h6, 64'h11, 5, 7, 3, 4'hf, 2, 3));

        @(negedge clk_i);
        e_dstE = 2; e_valE = 9; W_dstE = 2; W_valE = 1;
        #1; chk("no_load_use_opq", load_use_o, 0);
        q.push_back(mk("opq_e_priority", 4'h6, 64'h11, 9, 7, 3, 4'hf, 2, 3));

        @(negedge clk_i);
        clr_fwd(); W_dstM = 3; W_valM = 64'h1234;
        q.push_back(mk("opq_w_fwd_b", 4'h6, 64'h11, 5, 64'h1234, 3, 4'hf, 2, 3));

        @(negedge clk_i);
        clr_fwd(); M_dstE = 2; M_valE = 64'hA; W_dstM = 2; W_valM = 64'hB; M_dstM = 3; m_valM = 64'hC;
        q.push_back(mk("opq_m_fwd", 4'h6, 64'h11, 64'hA, 64'hC, 3, 4'hf, 2, 3));

        @(negedge clk_i);
        clr_fwd(); set_d(4'h8, 4'hf, 4'hf, 64'h50, 64'h40);
        #1; chk("call_srcA", srcA, 4'hf); chk("call_srcB", srcB, 4);
        q.push_back(mk("call", 4'h8, 64'h50, 64'h40, 64'h100, 4, 4'hf, 4'hf, 4));

        @(negedge clk_i);
        set_d(4'h3, 4'hf, 5, 64'h77, 64'h5a); e_dstE = 4'hf; e_valE = 64'h999;
        q.push_back(mk("irmovq_rnone", 4'h3, 64'h77, 0, 0, 5, 4'hf, 4'hf, 4'hf));

        @(negedge clk_i);
        clr_fwd(); set_d(4'h5, 1, 6, 64'h8, 64'h60);
        q.push_back(mk("mrmovq", 4'h5, 64'h8, 0, 64'h200, 4'hf, 1, 4'hf, 6));

        @(negedge clk_i);
        set_d(4'h6, 1, 2, 64'h33, 64'h70); stall_i = 1; bubble_i = 1;
        #1; chk("load_use_hit", load_use_o, 1);
        q.push_back(mk("stall_over_bubble", 4'h5, 64'h8, 0, 64'h200, 4'hf, 1, 4'hf, 6));

        @(negedge clk_i);
        stall_i = 0; bubble_i = 1;
        #1; chk("load_use_held", load_use_o, 1);
        q.push_back(bub("bubble"));

        @(negedge clk_i);
        bubble_i = 0;
        #1; chk("load_use_clear", load_use_o, 0);
        q.push_back(mk("opq_after_bubble", 4'h6, 64'h33, 64'h10, 5, 2, 4'hf, 1, 2));

        @(negedge clk_i);
        rst_i = 1; stall_i = 1; set_d(4'h6, 2, 3, 64'h44, 0);
        q.push_back(bub("reset_over_stall"));

        @(negedge clk_i);
        rst_i = 0; stall_i = 0;
        q.push_back(mk("opq_after_reset", 4'h6, 64'h44, 5, 7, 3, 4'hf, 2, 3));

        repeat (3) @(negedge clk_i);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            $display("FAIL %s: got no sample expected one at cycle %0d", e.name, e.due);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Y86-64 decode stage plus decode/execute pipeline register. Decodes the fetched instruction into register-file source and destination IDs and drives the register file's read addresses. Selects each operand from the register file or from the forwarding paths. Registers the result into the E-stage bundle. Sits between fetch (D register) and execute; the register file's two read ports are consumed combinationally within the cycle.

## Interface
Parameters:
- XLEN, 64, data width
- RNONE, 4'hf, "no register" ID (register file returns 0 / ignores writes)
- RSP, 4'h4, stack pointer ID

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- D_stat, D_icode, D_ifun, D_rA, D_rB  in  3/4/4/4/4  fetched instruction fields
- D_valC, D_valP  in  XLEN  constant and next PC
- srcA, srcB  out  4  register-file read addresses (combinational)
- valA, valB  in  XLEN  register-file read data (combinational)
- e_dstE, e_valE  in  4/XLEN  execute-stage result (this cycle's ALU output)
- M_dstE, M_valE, M_dstM, m_valM  in  4/XLEN/4/XLEN  memory-stage results
- W_dstE, W_valE, W_dstM, W_valM  in  4/XLEN/4/XLEN  writeback-stage results
- stall_i  in  1  hold E register
- bubble_i  in  1  load NOP bubble into E register
- E_stat, E_icode, E_ifun  out  3/4/4  registered bundle
- E_valC, E_valA, E_valB  out  XLEN  registered operands
- E_dstE, E_dstM, E_srcA, E_srcB  out  4  registered register IDs
- load_use_o  out  1  load/use hazard request to pipeline control (combinational)

## Operation
- Source/dest decode (combinational, by D_icode):
  - srcA: rA for RRMOVQ/RMMOVQ/OPQ/PUSHQ; RSP for POPQ/RET; else RNONE.
  - srcB: rB for OPQ/RMMOVQ/MRMOVQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
  - d_dstE: rB for RRMOVQ/IRMOVQ/OPQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
  - d_dstM: rA for MRMOVQ/POPQ; else RNONE.
- Conditional-move suppression of dstE belongs to execute, not here.
- Operand A select, first match wins:
  - D_icode in {CALL, JXX} → D_valP
  - srcA==e_dstE → e_valE
  - ==M_dstM → m_valM
  - ==M_dstE → M_valE
  - ==W_dstM → W_valM
  - ==W_dstE → W_valE
  - else valA
- Operand B select: same chain on srcB, without the valP term.
- A source of RNONE never matches a forwarding ID. It falls through to the register-file value, which is 0.
- E register update priority:
  - rst_i → bubble.
  - else stall_i → hold; stall wins over bubble.
  - else bubble_i → bubble.
  - else load the decoded bundle.
- Bubble contents:
  - icode NOP (4'h1), ifun 0, stat AOK
  - all four register IDs RNONE
  - valC/valA/valB 0
- load_use_o = (E_icode in {MRMOVQ, POPQ}) && (E_dstM != RNONE) && (E_dstM == srcA || E_dstM == srcB).
  - Pipeline control uses it to stall F/D and bubble E.
  - This block does not act on it internally.

## Timing
- Decode, forwarding and load_use_o are combinational from D inputs and registered E state. No internal pipelining.
- Latency: D fields → E outputs is 1 cycle.
- Reset is synchronous: outputs show the bubble from the first edge with rst_i high. Before that edge they are undefined.
- Reset mid-stream discards the in-flight instruction and overrides stall_i.
- Same-cycle write and read on the same register: the forwarded W value must be selected. Correctness must not depend on the register file's write timing.
- Several stages targeting the same register: the youngest (e) wins.

## Structure
- Shared package y86_pkg:
  - icode constants (HALT 0 … POPQ B)
  - RNONE, RSP
  - stat codes (AOK 1, HLT 2, ADR 3, INS 4)
  - E-bundle field widths
- One sub-module, fwd_sel: the priority forwarding mux, instantiated twice, with a valP-select enable used only for operand A.

## Test plan
- OPQ rA=2,rB=3, regfile r2=5, r3=7, no forwarding → srcA=2, srcB=3; next cycle E_valA=5, E_valB=7, E_dstE=3, E_dstM=F.
- Same OPQ with e_dstE=2,e_valE=9 and W_dstE=2,W_valE=1 → E_valA=9 (e priority).
- Same OPQ with W_dstM=3,W_valM=0x1234 while the regfile still holds the old r3=7 → E_valB=0x1234.
- CALL with D_valP=0x40 → srcA=F, srcB=4, E_valA=0x40, E_dstE=4.
- MRMOVQ rA=1 latched in E, then D=OPQ rA=1 → load_use_o=1.
  - Assert stall_i and bubble_i together → E holds the MRMOVQ.
  - Then bubble_i alone → E_icode=1, E_dstE/E_dstM=F.
- rst_i for one cycle during a stream with stall_i=1 → E_icode=1, stat AOK, all IDs F, values 0.
